uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Serial receive front end of the core's UART peripheral; consumes the UART_Rx line (looped from UART_Tx in the system bench) and delivers bytes to the memory-mapped UART register block read by the RISC-V core.
- 8N1 frame, LSB first, mid-bit sampling from a clock-cycle bit counter.
- Sticky ready/error flags are held until the CPU-side register block clears them.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz
- BAUD, 115200, line rate in bit/s
- CLKS_PER_BIT, CLK_FREQ/BAUD (434), derived localparam, clocks per bit; counter width is $clog2(CLKS_PER_BIT)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- rx_i  in  1  asynchronous serial line, idle high
- rx_clr  in  1  one-cycle pulse; clears rx_ready (CPU read of data register)
- err_clr  in  1  one-cycle pulse; clears frame_err and overrun
- rx_data  out  8  last good received byte
- rx_valid  out  1  one-cycle strobe when rx_data updates
- rx_ready  out  1  sticky "byte available"
- frame_err  out  1  sticky; stop bit sampled low
- overrun  out  1  sticky; good byte completed while rx_ready=1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - all outputs 0.
  - sync flops and previous-sample register set to 1.
  - FSM forced to IDLE and bit counter zeroed, including mid-frame.
- rx_i passes through a 2-flop synchronizer. All decisions use the synced value rxs, so there are 2 cycles of input latency.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - a falling edge on rxs (prev=1, now=0) clears the counter and moves to START.
  - a line held low without an edge never triggers a frame.
- START:
  - count to CLKS_PER_BIT/2-1, then sample rxs.
  - rxs=0 moves to DATA, with bit index 0 and counter cleared.
  - rxs=1 is treated as a glitch and returns to IDLE with no flags changed.
- DATA:
  - count to CLKS_PER_BIT-1, then shift rxs into the shift register MSB (LSB-first reception).
  - after index 7 moves to STOP; otherwise increments the index.
- STOP:
  - count to CLKS_PER_BIT-1, then sample rxs and return to IDLE.
  - rxs=1: next cycle rx_data<=shift register, rx_valid=1 for exactly one cycle, rx_ready<=1, and overrun<=1 if rx_ready was already 1. Data is overwritten.
  - rxs=0: next cycle frame_err<=1. rx_data, rx_ready and rx_valid are unchanged.
- Latency: rx_valid rises 3 cycles after the stop-bit sample point (2 sync + 1 register). That is about 9.5 bit times plus 3 cycles from the line's falling edge.
- Simultaneous events:
  - set and clear of the same flag in one cycle: set wins.
  - rx_clr and err_clr are independent of each other.
- busy = (state != IDLE). It drops in the cycle after the stop sample.
- The counter never wraps past its terminal count; it is cleared on every state or bit transition.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - adds state PARITY between DATA and STOP.
  - adds parameter PARITY_ODD (default 0, even parity).
  - adds output parity_err (sticky, cleared by err_clr, reset 0).
  - on a parity mismatch, parity_err<=1 and the byte is discarded (no rx_valid, rx_ready unchanged), but STOP is still sampled so the frame stays aligned.
- Not defined: pure 8N1, no parity_err port, no PARITY state.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - DATA_BITS=8
  - function clks_per_bit(clk_freq, baud) returning integer
- The shared uart_tx uses the same package.
- Sub-module sync_2ff (reset value parameter RST_VAL=1), a generic 2-flop synchronizer reusable for GPIO_In.

Test Plan:
- Good byte: 434 clk/bit; idle high, then send 0x55 8N1 → exactly one rx_valid pulse, rx_data=0x55, rx_ready=1, frame_err=0, busy low after the stop sample.
- Glitch rejection: rx_i low for 100 cycles, then high → no rx_valid, busy returns 0 by START mid-sample (cycle ~219), all flags 0.
- Framing error: send 0xA5 with the stop bit driven low → frame_err=1, rx_ready=0, rx_data keeps its previous value 0x55. err_clr pulse → frame_err=0.
- Overrun and clear priority: send 0x12 then 0x34 without rx_clr → overrun=1, rx_data=0x34. Pulse rx_clr in the same cycle as a new byte's set → rx_ready stays 1.
- Reset mid-frame: assert rst for 1 cycle during DATA bit 3 → all outputs 0, busy=0. The following frame 0xC3 is received correctly.
- Parity (UART_RX_PARITY_EN, PARITY_ODD=0):
  - 0x07 with parity bit 1 → accepted.
  - 0x07 with parity bit 0 → parity_err=1, no rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud helper.
// Used by both uart_rx_core and uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int DATA_BITS = 8;

    function automatic integer clks_per_bit(input integer clk_freq, input integer baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs
// (serial lines, GPIO). Both stages reset to RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 8 data bits, LSB first, mid-bit sampling, sticky status flags.
// Optional parity bit enabled by defining UART_RX_PARITY_EN (adds PARITY_ODD
// parameter and parity_err output).
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    input  logic                 rx_clr,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rxs;
    logic                 rxs_prev;
    uart_state_t          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 byte_done;
    logic                 stop_bad;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 par_fail;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_i),
        .q   (rxs)
    );

    // FSM state, bit timing counter, bit index, shift register and edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            rxs_prev  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            rxs_prev  <= rxs;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Next-state logic; byte_done/stop_bad flag the stop-bit sample outcome.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        par_fail  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rxs_prev && !rxs) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d = DATA;
                        idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    if (rxs != ((^shift_q) ^ PARITY_ODD)) begin
                        par_bad_d = 1'b1;
                        par_fail  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rxs) begin
`ifdef UART_RX_PARITY_EN
                        byte_done = !par_bad_q;
`else
                        byte_done = 1'b1;
`endif
                    end else begin
                        stop_bad = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output data and sticky flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_ready   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid <= byte_done;
            if (byte_done) begin
                rx_data <= shift_q;
            end
            if (byte_done) begin
                rx_ready <= 1'b1;
            end else if (rx_clr) begin
                rx_ready <= 1'b0;
            end
            if (byte_done && rx_ready) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
            if (stop_bad) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            if (par_fail) begin
                parity_err <= 1'b1;
            end else if (err_clr) begin
                parity_err <= 1'b0;
            end
`endif
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames plus random bytes
// compared against a frame-level reference model of the receiver flags.
// Parity frames are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx_core;

    localparam int CPB = 50_000_000 / 115200;   // 434 clocks per bit
`ifdef UART_RX_PARITY_EN
    localparam int  NBITS = 11;
    localparam bit  PAR   = 1'b1;
`else
    localparam int  NBITS = 10;
    localparam bit  PAR   = 1'b0;
`endif
    localparam bit  PODD  = 1'b0;
    // Line fall -> edge detect (3), half bit to start centre, then NBITS-1 full
    // bits to the stop centre; rx_valid is registered on that sample edge.
    localparam int  VALID_CYC = 3 + CPB / 2 + (NBITS - 1) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic       rx_clr = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready, frame_err, overrun, busy;
    logic       parity_err_w;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_data  = '0;
    logic       m_ready = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_perr  = 1'b0;

    always #5 clk = ~clk;

    uart_rx_core #(
        .CLK_FREQ (50_000_000),
        .BAUD     (115200)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD (PODD)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (rx_i),
        .rx_clr    (rx_clr),
        .err_clr   (err_clr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err_w),
`endif
        .busy      (busy)
    );

`ifndef UART_RX_PARITY_EN
    assign parity_err_w = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".rx_data"},    32'(rx_data),      32'(m_data));
        check_eq({tag, ".rx_ready"},   32'(rx_ready),     32'(m_ready));
        check_eq({tag, ".frame_err"},  32'(frame_err),    32'(m_ferr));
        check_eq({tag, ".overrun"},    32'(overrun),      32'(m_ovr));
        check_eq({tag, ".parity_err"}, 32'(parity_err_w), 32'(m_perr));
        check_eq({tag, ".busy"},       32'(busy),         32'(0));
        check_eq({tag, ".rx_valid"},   32'(rx_valid),     32'(0));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle pulses on the CPU-side clear inputs while the line is idle.
    task automatic pulse_clears(input logic c_rx, input logic c_err);
        @(posedge clk);
        #1;
        rx_clr  = c_rx;
        err_clr = c_err;
        @(posedge clk);
        #1;
        rx_clr  = 1'b0;
        err_clr = 1'b0;
        if (c_rx) m_ready = 1'b0;
        if (c_err) begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            m_perr = 1'b0;
        end
    endtask

    // Drives one frame bit-serially; optionally pulses rx_clr or rst at a given
    // cycle (rst aborts the frame and returns the line to idle).
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input int clr_at, input int rst_at,
                              output int nvalid, output int vcyc);
        logic [10:0] bits;
        bit aborted;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = b;
        if (PAR) begin
            bits[9]  = par;
            bits[10] = stop;
        end else begin
            bits[9] = stop;
        end
        nvalid  = 0;
        vcyc    = -1;
        aborted = 1'b0;
        for (int c = 0; c < NBITS * CPB + 8; c++) begin
            @(posedge clk);
            #1;
            if (rx_valid) begin
                nvalid++;
                vcyc = c;
            end
            rst    = (c == rst_at);
            rx_clr = (c == clr_at);
            if (c == rst_at) aborted = 1'b1;
            if (aborted || (c / CPB) >= NBITS) rx_i = 1'b1;
            else rx_i = bits[c / CPB];
        end
        rst    = 1'b0;
        rx_clr = 1'b0;
        rx_i   = 1'b1;
    endtask

    // Frame-level reference: decide accept/reject from the frame contents.
    task automatic run_frame(input string tag, input logic [7:0] b, input logic par,
                             input logic stop, input int clr_at);
        int  nv, vc;
        bit  pbad, good;
        pbad = PAR && (par != ((^b) ^ PODD));
        good = stop && !pbad;
        send_frame(b, par, stop, clr_at, -1, nv, vc);
        if (pbad) m_perr = 1'b1;
        if (!stop) m_ferr = 1'b1;
        if (good) begin
            m_ovr   = m_ovr | m_ready;
            m_ready = 1'b1;
            m_data  = b;
        end else if (clr_at >= 0) begin
            m_ready = 1'b0;
        end
        check_eq({tag, ".valid_count"}, 32'(nv), good ? 32'd1 : 32'd0);
        check_eq({tag, ".valid_cycle"}, 32'(vc), good ? 32'(VALID_CYC) : 32'hFFFF_FFFF);
        idle_cycles(4);
        check_outputs(tag);
    endtask

    // Short low pulse on the line: must be rejected at the start-bit centre.
    task automatic glitch(input int low_len);
        int nv;
        nv = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (rx_valid) nv++;
            if (c == 50) check_eq("glitch.busy_mid", 32'(busy), 32'd1);
            rx_i = (c < low_len) ? 1'b0 : 1'b1;
        end
        check_eq("glitch.valid_count", 32'(nv), 32'd0);
        check_outputs("glitch");
    endtask

    function automatic logic good_par(input logic [7:0] b);
        return (^b) ^ PODD;
    endfunction

    initial begin
        int nv, vc;
        logic [7:0] b;
        logic st, pr;

        rst = 1'b1;
        idle_cycles(5);
        rst = 1'b0;
        idle_cycles(3);
        check_outputs("reset");

        run_frame("good55", 8'h55, good_par(8'h55), 1'b1, -1);

        glitch(100);

        pulse_clears(1'b1, 1'b0);
        run_frame("frameA5", 8'hA5, good_par(8'hA5), 1'b0, -1);
        pulse_clears(1'b0, 1'b1);
        check_outputs("err_clr");

        run_frame("ovr12", 8'h12, good_par(8'h12), 1'b1, -1);
        run_frame("ovr34", 8'h34, good_par(8'h34), 1'b1, -1);
        run_frame("clr_same", 8'h9E, good_par(8'h9E), 1'b1, VALID_CYC - 1);
        pulse_clears(1'b1, 1'b1);
        check_outputs("clr_both");

        // Reset while the receiver is shifting data bit 3.
        send_frame(8'h6B, good_par(8'h6B), 1'b1, -1, 4 * CPB + 164, nv, vc);
        m_data = '0; m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        idle_cycles(4);
        check_eq("rst_mid.valid_count", 32'(nv), 32'd0);
        check_outputs("rst_mid");
        run_frame("afterC3", 8'hC3, good_par(8'hC3), 1'b1, -1);

`ifdef UART_RX_PARITY_EN
        pulse_clears(1'b1, 1'b1);
        run_frame("par07_ok", 8'h07, 1'b1, 1'b1, -1);
        run_frame("par07_bad", 8'h07, 1'b0, 1'b1, -1);
        pulse_clears(1'b1, 1'b1);
`endif

        for (int i = 0; i < 6; i++) begin
            b  = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            pr = good_par(b);
            if (PAR && $urandom_range(0, 3) == 0) pr = ~pr;
            run_frame("rand", b, pr, st, -1);
            pulse_clears(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            idle_cycles(int'($urandom_range(2, 50)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
